// File: rtl/ccff_bitstream_loader.sv
// Serializes host bitstream words MSB-first onto the ccff configuration chain.
// Optional CCFF_TAIL_CHECK_EN counts 1s leaving the chain tail during a load.
module ccff_bitstream_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN+1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  tail_ones
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int REM    = CHAIN_LEN % WORD_W;
  localparam int LBITS  = (REM == 0) ? WORD_W : REM;
  localparam int BW     = $clog2(WORD_W+1);
  localparam int AW     = $clog2(NWORDS+1);

  localparam logic [BW-1:0]    FULL_B = BW'(WORD_W);
  localparam logic [BW-1:0]    LAST_B = BW'(LBITS);
  localparam logic [BW-1:0]    ONE_B  = BW'(1);
  localparam logic [AW-1:0]    NW     = AW'(NWORDS);
  localparam logic [AW-1:0]    NW_M1  = AW'(NWORDS-1);
  localparam logic [AW-1:0]    ONE_A  = AW'(1);
  localparam logic [CNT_W-1:0] LEN    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] sr;
  logic [WORD_W-1:0] hold;
  logic [BW-1:0]     sr_cnt;
  logic [BW-1:0]     hold_bits;
  logic              hold_full;
  logic [AW-1:0]     acc_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic              hs;
  logic [BW-1:0]     in_bits;

  assign word_ready = (state == LOAD) && !hold_full
                    && (acc_cnt != NW);
  assign hs         = word_valid && word_ready;
  // The final word only carries the bits that still fit in the chain
  assign in_bits    = (acc_cnt == NW_M1) ? LAST_B : FULL_B;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state     <= IDLE;
      sr        <= '0;
      hold      <= '0;
      sr_cnt    <= '0;
      hold_bits <= '0;
      hold_full <= 1'b0;
      acc_cnt   <= '0;
      bit_cnt   <= '0;
      ccff_head <= 1'b0;
      shift_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          shift_en <= 1'b0;
          if (start) begin
            state     <= LOAD;
            busy      <= 1'b1;
            done      <= 1'b0;
            sr        <= '0;
            hold      <= '0;
            sr_cnt    <= '0;
            hold_bits <= '0;
            hold_full <= 1'b0;
            acc_cnt   <= '0;
            bit_cnt   <= '0;
          end
        end
        LOAD: begin
          if (bit_cnt == LEN) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            shift_en <= 1'b0;
          end else begin
            if (hs) acc_cnt <= acc_cnt + ONE_A;
            unique case (1'b1)
              (sr_cnt != '0): begin
                ccff_head <= sr[WORD_W-1];
                shift_en  <= 1'b1;
                bit_cnt   <= bit_cnt + ONE_C;
                if (sr_cnt == ONE_B && hold_full) begin
                  sr        <= hold;
                  sr_cnt    <= hold_bits;
                  hold_full <= 1'b0;
                end else begin
                  sr     <= sr << 1;
                  sr_cnt <= sr_cnt - ONE_B;
                end
                if (hs) begin
                  hold      <= word_data;
                  hold_bits <= in_bits;
                  hold_full <= 1'b1;
                end
              end
              (sr_cnt == '0 && hold_full): begin
                ccff_head <= hold[WORD_W-1];
                shift_en  <= 1'b1;
                bit_cnt   <= bit_cnt + ONE_C;
                sr        <= hold << 1;
                sr_cnt    <= hold_bits - ONE_B;
                hold_full <= 1'b0;
              end
              (sr_cnt == '0 && !hold_full && hs): begin
                ccff_head <= word_data[WORD_W-1];
                shift_en  <= 1'b1;
                bit_cnt   <= bit_cnt + ONE_C;
                sr        <= word_data << 1;
                sr_cnt    <= in_bits - ONE_B;
              end
              default: shift_en <= 1'b0;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CCFF_TAIL_CHECK_EN
  logic [CNT_W-1:0] tail_q;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      tail_q <= '0;
    end else if (start && state != LOAD) begin
      tail_q <= '0;
    end else if (shift_en && ccff_tail && tail_q != LEN) begin
      tail_q <= tail_q + ONE_C;
    end
  end

  assign tail_ones = tail_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign tail_ones   = '0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench for ccff_bitstream_loader (WORD_W=8, CHAIN_LEN=20).
// Expected chain bits are queued per load; a negedge monitor checks them.
module tb_ccff_bitstream_loader;
  localparam int W  = 8;
  localparam int L  = 20;
  localparam int CW = 5;
  localparam logic [19:0] EXP = 20'hA53CF;
`ifdef CCFF_TAIL_CHECK_EN
  localparam int EXP_TAIL = 12;
`else
  localparam int EXP_TAIL = 0;
`endif

  logic          prog_clk = 1'b0;
  logic          pReset_n;
  logic          start;
  logic [W-1:0]  word_data;
  logic          word_valid;
  logic          word_ready;
  logic          ccff_head;
  logic          shift_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic [CW-1:0] tail_ones;

  ccff_bitstream_loader #(
    .WORD_W(W), .CHAIN_LEN(L), .CNT_W(CW)
  ) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n),
    .start(start), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready),
    .ccff_head(ccff_head), .shift_en(shift_en),
    .ccff_tail(ccff_tail), .busy(busy),
    .done(done), .tail_ones(tail_ones)
  );

  always #5 prog_clk = ~prog_clk;

  int compared = 0;
  int mismatched = 0;
  logic exp_q[$];
  int cyc = 0;
  int shifts = 0;
  int first_c = -1;
  int last_c = -1;
  int done_c = -1;

  logic [19:0] chain;
  logic        preload;
  assign ccff_tail = chain[19];

  always @(posedge prog_clk) begin
    if (preload) chain <= 20'hFFF00;
    else if (shift_en === 1'b1) chain <= {chain[18:0], ccff_head};
  end

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge prog_clk) begin
    logic e;
    cyc++;
    if (pReset_n === 1'b1 && shift_en === 1'b1) begin
      shifts++;
      if (first_c < 0) first_c = cyc;
      last_c = cyc;
      if (exp_q.size() == 0) begin
        chk("extra_shift", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ccff_head", int'(ccff_head), int'(e));
      end
    end
    if (done === 1'b1 && done_c < 0) done_c = cyc;
  end

  task automatic load_setup();
    logic [19:0] v;
    v = EXP;
    exp_q.delete();
    for (int i = 19; i >= 0; i--) exp_q.push_back(v[i]);
    shifts = 0;
    first_c = -1;
    last_c = -1;
    done_c = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    word_data = w;
    word_valid = 1'b1;
    while (word_ready !== 1'b1 && n < 50) begin
      @(negedge prog_clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
    @(negedge prog_clk);
    word_valid = 1'b0;
  endtask

  task automatic send3();
    send(8'hA5);
    send(8'h3C);
    send(8'hF0);
  endtask

  task automatic wait_done(input string nm, input int span,
                           input bit tail_chk);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge prog_clk);
      n++;
    end
    if (n >= 200) chk({nm, "_done_timeout"}, 0, 1);
    #1;
    chk({nm, "_shifts"}, shifts, L);
    chk({nm, "_span"}, last_c - first_c + 1, span);
    chk({nm, "_done_lat"}, done_c - last_c, 1);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_shift_en"}, int'(shift_en), 0);
    chk({nm, "_ready"}, int'(word_ready), 0);
    chk({nm, "_leftover"}, exp_q.size(), 0);
    if (tail_chk) chk({nm, "_tail"}, int'(tail_ones), EXP_TAIL);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    start = 1'b0;
    word_valid = 1'b0;
    word_data = '0;
    preload = 1'b0;
    pReset_n = 1'b1;
    repeat (2) @(negedge prog_clk);
    #2 pReset_n = 1'b0;
    #1;
    chk("rst_ready", int'(word_ready), 0);
    chk("rst_shift_en", int'(shift_en), 0);
    chk("rst_head", int'(ccff_head), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tail", int'(tail_ones), 0);
    @(negedge prog_clk);
    pReset_n = 1'b1;
    word_valid = 1'b1;
    word_data = 8'hFF;
    repeat (5) @(negedge prog_clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_ready", int'(word_ready), 0);
    chk("idle_shift_en", int'(shift_en), 0);
    chk("idle_done", int'(done), 0);
    word_valid = 1'b0;

    preload = 1'b1;
    @(negedge prog_clk);
    preload = 1'b0;

    load_setup();
    pulse_start();
    chk("start_busy", int'(busy), 1);
    chk("start_ready", int'(word_ready), 1);
    send3();
    wait_done("b2b", 20, 1'b1);

    load_setup();
    pulse_start();
    send(8'hA5);
    repeat (10) @(negedge prog_clk);
    send(8'h3C);
    send(8'hF0);
    wait_done("underrun", 23, 1'b1);

    load_setup();
    pulse_start();
    fork
      send3();
      begin
        n = 0;
        while (shifts < 10 && n < 100) begin
          @(negedge prog_clk);
          n++;
        end
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
      end
    join
    wait_done("ign_start", 20, 1'b1);

    load_setup();
    pulse_start();
    chk("restart_done", int'(done), 0);
    chk("restart_busy", int'(busy), 1);
    send3();
    wait_done("reload", 20, 1'b1);

    load_setup();
    pulse_start();
    send(8'hA5);
    send(8'h3C);
    n = 0;
    while (shifts < 7 && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    #2 pReset_n = 1'b0;
    #1;
    chk("mid_rst_shift_en", int'(shift_en), 0);
    chk("mid_rst_ready", int'(word_ready), 0);
    chk("mid_rst_busy", int'(busy), 0);
    exp_q.delete();
    @(negedge prog_clk);
    pReset_n = 1'b1;
    @(negedge prog_clk);

    load_setup();
    pulse_start();
    send3();
    wait_done("post_rst", 20, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
